ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 198 +++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module  : ps2_key_tracker
// Brief   : PS/2 keyboard frame receiver with held-key tracker, ASCII map and
//           press counter. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic [7:0] scan_code,
  output logic [7:0] ascii,
  output logic       key_valid,
  output logic [7:0] key_count,
  output logic       parity_err
);

  localparam int              c_TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam [c_TO_WIDTH-1:0] c_TO_LAST  = c_TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      c_BREAK    = 8'hF0;
  localparam logic [7:0]      c_EXT      = 8'hE0;
  localparam logic [3:0]      c_LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HELD       = 2'd1,
    ST_BREAK_PEND = 2'd2
  } state_t;

  logic [2:0]            r_ps2_sync;
  logic [3:0]            r_bit_cnt;
  logic [10:0]           r_frame;
  logic [c_TO_WIDTH-1:0] r_to_cnt;
  logic                  r_byte_valid;
  logic [7:0]            r_byte_data;
  state_t                r_state;
  logic [7:0]            r_scan;
  logic [7:0]            r_ascii;
  logic                  r_key_valid;
  logic [7:0]            r_key_count;

  logic                  w_fall;
  logic [10:0]           w_frame_next;
  logic                  w_frame_done;
  logic                  w_framing_ok;
  logic                  w_accept;
  state_t                w_state_next;
  logic [7:0]            w_scan_next;
  logic                  w_key_valid_next;
  logic [7:0]            w_count_next;

  assign w_fall       = r_ps2_sync[2] & ~r_ps2_sync[1];
  // Start bit enters first and ends up in bit 0 after the 11th shift.
  assign w_frame_next = {ps2_data, r_frame[10:1]};
  assign w_frame_done = w_fall && (r_bit_cnt == c_LAST_BIT);
  assign w_framing_ok = ~w_frame_next[0] & w_frame_next[10];

`ifdef PS2_PARITY_CHECK_EN
  logic w_parity_ok;
  logic r_parity_err;

  assign w_parity_ok = ^w_frame_next[9:1];
  assign w_accept    = w_frame_done & w_framing_ok & w_parity_ok;
  assign parity_err  = r_parity_err;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_parity_err <= 1'b0;
    else       r_parity_err <= w_frame_done & w_framing_ok & ~w_parity_ok;
  end
`else
  assign w_accept   = w_frame_done & w_framing_ok;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ps2_sync   <= 3'b111;
      r_bit_cnt    <= 4'd0;
      r_frame      <= 11'd0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
    end else begin
      r_ps2_sync   <= {r_ps2_sync[1:0], ps2_clk};
      r_byte_valid <= w_accept;
      if (w_accept) r_byte_data <= w_frame_next[8:1];
      if (w_fall) begin
        r_frame  <= w_frame_next;
        r_to_cnt <= '0;
        r_bit_cnt <= w_frame_done ? 4'd0 : r_bit_cnt + 4'd1;
      end else if (r_bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped so the next start bit realigns.
        if (r_to_cnt == c_TO_LAST) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    case (code)
      8'h1C: ascii_of = 8'h61;  8'h32: ascii_of = 8'h62;  8'h21: ascii_of = 8'h63;
      8'h23: ascii_of = 8'h64;  8'h24: ascii_of = 8'h65;  8'h2B: ascii_of = 8'h66;
      8'h34: ascii_of = 8'h67;  8'h33: ascii_of = 8'h68;  8'h43: ascii_of = 8'h69;
      8'h3B: ascii_of = 8'h6A;  8'h42: ascii_of = 8'h6B;  8'h4B: ascii_of = 8'h6C;
      8'h3A: ascii_of = 8'h6D;  8'h31: ascii_of = 8'h6E;  8'h44: ascii_of = 8'h6F;
      8'h4D: ascii_of = 8'h70;  8'h15: ascii_of = 8'h71;  8'h2D: ascii_of = 8'h72;
      8'h1B: ascii_of = 8'h73;  8'h2C: ascii_of = 8'h74;  8'h3C: ascii_of = 8'h75;
      8'h2A: ascii_of = 8'h76;  8'h1D: ascii_of = 8'h77;  8'h22: ascii_of = 8'h78;
      8'h35: ascii_of = 8'h79;  8'h1A: ascii_of = 8'h7A;
      8'h45: ascii_of = 8'h30;  8'h16: ascii_of = 8'h31;  8'h1E: ascii_of = 8'h32;
      8'h26: ascii_of = 8'h33;  8'h25: ascii_of = 8'h34;  8'h2E: ascii_of = 8'h35;
      8'h36: ascii_of = 8'h36;  8'h3D: ascii_of = 8'h37;  8'h3E: ascii_of = 8'h38;
      8'h46: ascii_of = 8'h39;
      8'h29: ascii_of = 8'h20;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    w_state_next     = r_state;
    w_scan_next      = r_scan;
    w_key_valid_next = r_key_valid;
    w_count_next     = r_key_count;
    // Extended-key prefix carries no information for this tracker.
    if (r_byte_valid && (r_byte_data != c_EXT)) begin
      case (r_state)
        ST_IDLE: begin
          if (r_byte_data == c_BREAK) begin
            w_state_next = ST_BREAK_PEND;
          end else begin
            w_scan_next      = r_byte_data;
            w_key_valid_next = 1'b1;
            w_count_next     = r_key_count + 8'd1;
            w_state_next     = ST_HELD;
          end
        end
        ST_HELD: begin
          if (r_byte_data == r_scan) begin
            w_state_next = ST_HELD;
          end else if (r_byte_data == c_BREAK) begin
            w_state_next = ST_BREAK_PEND;
          end else begin
            w_scan_next  = r_byte_data;
            w_count_next = r_key_count + 8'd1;
          end
        end
        ST_BREAK_PEND: begin
          if ((r_byte_data == r_scan) && r_key_valid) begin
            w_key_valid_next = 1'b0;
            w_state_next     = ST_IDLE;
          end else begin
            w_state_next = r_key_valid ? ST_HELD : ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= ST_IDLE;
      r_scan      <= 8'd0;
      r_ascii     <= 8'd0;
      r_key_valid <= 1'b0;
      r_key_count <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_scan      <= w_scan_next;
      r_ascii     <= ascii_of(w_scan_next);
      r_key_valid <= w_key_valid_next;
      r_key_count <= w_count_next;
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign scan_code  = r_scan;
  assign ascii      = r_ascii;
  assign key_valid  = r_key_valid;
  assign key_count  = r_key_count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
// ============================================================================
// Module  : tb_ps2_key_tracker
// Brief   : Self-checking bench for ps2_key_tracker against a key-state model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_tracker;

  localparam int TIMEOUT = 200;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [7:0] scan_code;
  logic [7:0] ascii;
  logic       key_valid;
  logic [7:0] key_count;
  logic       parity_err;

  int errors = 0;
  int checks = 0;
  int bv_cnt = 0;
  int pe_cnt = 0;

  // Model: the last key pressed, whether it is held, presses so far, and
  // whether a release prefix is waiting for its key code.
  logic [7:0] m_scan, m_count, m_byte;
  logic       m_valid, m_brk;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .scan_code(scan_code),
    .ascii(ascii), .key_valid(key_valid), .key_count(key_count),
    .parity_err(parity_err));

  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (parity_err) pe_cnt++;
  end

  function automatic logic [7:0] ref_ascii(input logic [7:0] code);
    ref_ascii = 8'h00;
    for (int i = 0; i < 26; i++) if (code == LETTERS[i]) ref_ascii = 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (code == DIGITS[i]) ref_ascii = 8'(8'h30 + i);
    if (code == 8'h29) ref_ascii = 8'h20;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_count = 0; m_byte = 0; m_valid = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_byte = b;
    if (b == 8'hE0) return;
    if (m_brk) begin
      m_brk = 0;
      if (m_valid && b == m_scan) m_valid = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_valid) begin
      m_valid = 1; m_scan = b; m_count = m_count + 8'd1;
    end else if (b != m_scan) begin
      m_scan = b; m_count = m_count + 8'd1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    ps2_clk  = 1'b1;
    wait_cycles(2);
    ps2_clk  = 1'b0;
    wait_cycles(3);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(6);
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    wait_cycles(3);
    clrn = 1'b1;
    model_reset();
    wait_cycles(3);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    wait_cycles(3);
    checks++;
    if ({byte_valid, byte_data, scan_code, ascii, key_valid, key_count, parity_err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0",
               {byte_valid, byte_data, scan_code, ascii, key_valid, key_count, parity_err});
    end
    clrn = 1'b1;
    model_reset();
    wait_cycles(5);
    checks++;
    if ({byte_valid, byte_data, scan_code, ascii, key_valid, key_count, parity_err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_released: got %h expected 0",
               {byte_valid, byte_data, scan_code, ascii, key_valid, key_count, parity_err});
    end
  endtask

  task automatic test_first_key();
    int bv0 = bv_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    model_byte(8'h1C);
    checks++;
    if (bv_cnt - bv0 !== 1) begin
      errors++; $display("FAIL first_key_pulse: got %0d pulses expected 1", bv_cnt - bv0);
    end
    checks++;
    if ({byte_data, scan_code, ascii, key_valid, key_count} !== {8'h1C, 8'h1C, 8'h61, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL first_key: got %h expected %h",
               {byte_data, scan_code, ascii, key_valid, key_count}, {8'h1C, 8'h1C, 8'h61, 1'b1, 8'h01});
    end
  endtask

  task automatic test_repeat_release();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], 1'b0, 1'b0);
      model_byte(seq[i]);
    end
    checks++;
    if ({scan_code, ascii, key_valid, key_count} !== {8'h1C, 8'h61, 1'b0, 8'h01}) begin
      errors++;
      $display("FAIL repeat_release: got %h expected %h",
               {scan_code, ascii, key_valid, key_count}, {8'h1C, 8'h61, 1'b0, 8'h01});
    end
  endtask

  task automatic test_parity();
    int bv0 = bv_cnt;
    int pe0 = pe_cnt;
    send_frame(8'h45, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    checks++;
    if ({bv_cnt - bv0, pe_cnt - pe0} !== {32'd0, 32'd1}) begin
      errors++;
      $display("FAIL parity_reject: got bv=%0d pe=%0d expected bv=0 pe=1", bv_cnt - bv0, pe_cnt - pe0);
    end
`else
    model_byte(8'h45);
    checks++;
    if ({bv_cnt - bv0, pe_cnt - pe0} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL parity_ignored: got bv=%0d pe=%0d expected bv=1 pe=0", bv_cnt - bv0, pe_cnt - pe0);
    end
`endif
    checks++;
    if ({byte_data, scan_code, ascii, key_valid, key_count} !== {m_byte, m_scan, ref_ascii(m_scan), m_valid, m_count}) begin
      errors++;
      $display("FAIL parity_outputs: got %h expected %h", {byte_data, scan_code, ascii, key_valid, key_count},
               {m_byte, m_scan, ref_ascii(m_scan), m_valid, m_count});
    end
  endtask

  task automatic test_bad_stop();
    int bv0 = bv_cnt;
    send_frame(8'h32, 1'b0, 1'b1);
    checks++;
    if (bv_cnt - bv0 !== 0) begin
      errors++; $display("FAIL bad_stop_pulse: got %0d pulses expected 0", bv_cnt - bv0);
    end
    checks++;
    if ({byte_data, scan_code, key_valid, key_count} !== {m_byte, m_scan, m_valid, m_count}) begin
      errors++;
      $display("FAIL bad_stop_outputs: got %h expected %h",
               {byte_data, scan_code, key_valid, key_count}, {m_byte, m_scan, m_valid, m_count});
    end
  endtask

  task automatic test_timeout();
    int bv0;
    logic [4:0] partial = 5'b11010;
    for (int i = 0; i < 5; i++) send_bit(partial[i]);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(TIMEOUT + 10);
    bv0 = bv_cnt;
    send_frame(8'h16, 1'b0, 1'b0);
    model_byte(8'h16);
    checks++;
    if (bv_cnt - bv0 !== 1) begin
      errors++; $display("FAIL timeout_pulse: got %0d pulses expected 1", bv_cnt - bv0);
    end
    checks++;
    if ({byte_data, ascii, scan_code, key_count} !== {8'h16, 8'h31, m_scan, m_count}) begin
      errors++;
      $display("FAIL timeout_realign: got %h expected %h",
               {byte_data, ascii, scan_code, key_count}, {8'h16, 8'h31, m_scan, m_count});
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h29, 8'hF0, 8'hE0, 8'h5A};
    logic [7:0] b;
    for (int n = 0; n < 60; n++) begin
      b = ($urandom_range(0, 4) == 0) ? m_scan : pool[$urandom_range(0, 7)];
      send_frame(b, 1'b0, 1'b0);
      model_byte(b);
      checks++;
      if ({byte_data, scan_code, ascii, key_valid, key_count} !==
          {m_byte, m_scan, ref_ascii(m_scan), m_valid, m_count}) begin
        errors++;
        $display("FAIL random_%0d byte %h: got %h expected %h", n, b,
                 {byte_data, scan_code, ascii, key_valid, key_count},
                 {m_byte, m_scan, ref_ascii(m_scan), m_valid, m_count});
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    clrn = 1'b0;
    wait_cycles(2);
    checks++;
    if ({byte_valid, byte_data, scan_code, ascii, key_valid, key_count, parity_err} !== 35'd0) begin
      errors++;
      $display("FAIL midframe_reset: got %h expected 0",
               {byte_valid, byte_data, scan_code, ascii, key_valid, key_count, parity_err});
    end
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(2);
    clrn = 1'b1;
    model_reset();
    wait_cycles(3);
    send_frame(8'h29, 1'b0, 1'b0);
    model_byte(8'h29);
    checks++;
    if ({scan_code, ascii, key_valid, key_count} !== {8'h29, 8'h20, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL midframe_recover: got %h expected %h",
               {scan_code, ascii, key_valid, key_count}, {8'h29, 8'h20, 1'b1, 8'h01});
    end
  endtask

  task automatic test_wrap();
    logic [7:0] k;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      k = i[0] ? 8'h32 : 8'h1C;
      send_frame(k, 1'b0, 1'b0);
      model_byte(k);
      checks++;
      if (key_count !== m_count) begin
        errors++; $display("FAIL wrap_press_%0d: got %h expected %h", i, key_count, m_count);
      end
      if (i == 254) begin
        checks++;
        if (key_count !== 8'hFF) begin
          errors++; $display("FAIL wrap_ff: got %h expected ff", key_count);
        end
      end
      send_frame(8'hF0, 1'b0, 1'b0);
      model_byte(8'hF0);
      send_frame(k, 1'b0, 1'b0);
      model_byte(k);
    end
    checks++;
    if ({key_count, key_valid, scan_code} !== {8'h00, 1'b0, 8'h32}) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected %h", {key_count, key_valid, scan_code}, {8'h00, 1'b0, 8'h32});
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_key();
    test_repeat_release();
    test_parity();
    test_bad_stop();
    test_timeout();
    test_random();
    test_reset_midframe();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
